online_quotient_collector: RTL and testbench

- Sink for the online divider's quotient digit stream.
- Accepts one signed-digit quotient digit per valid/ready handshake, MSD first.
- Converts the digits on the fly (Ercegovac–Lang Q/QM registers) to a conventional two's-complement word.
- Presents the finished word on a parallel valid/ready port once NDIG digits are collected; sits between the divider's output handshake and downstream parallel logic.

---
 rtl/online_quotient_collector_pkg.sv | 19 +
 rtl/online_quotient_collector_otf_converter.sv | 46 ++++
 rtl/online_quotient_collector.sv | 103 ++++++++++
 tb/tb_online_quotient_collector.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/online_quotient_collector_pkg.sv
// Shared definitions for the online quotient collector: signed-digit
// encoding of the incoming quotient digits and the collector state type.
package online_quotient_collector_pkg;

   // Signed-digit quotient encoding: bit1 = plus, bit0 = minus.
   typedef logic [1:0] sd_digit_t;

   localparam sd_digit_t SD_ZERO = 2'b00;
   localparam sd_digit_t SD_NEG  = 2'b01;
   localparam sd_digit_t SD_POS  = 2'b10;
   localparam sd_digit_t SD_BAD  = 2'b11;  // redundant zero, flagged as an error

   // COLLECT accepts digits, HOLD presents the finished word.
   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } state_t;

endpackage : online_quotient_collector_pkg

// File: rtl/online_quotient_collector_otf_converter.sv
// On-the-fly converter: the Q/QM register pair that turns an MSD-first
// signed-digit stream into a two's-complement word without any carry chain.
// QM always tracks Q - 1, so a -1 digit appends to QM instead of borrowing.
module otf_converter
   import online_quotient_collector_pkg::*;
#(
   parameter int NDIG = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clr,
   input  logic            en,
   input  sd_digit_t       digit,
   output logic [NDIG:0]   q,
   output logic [NDIG:0]   qm
);

   // Shift the next digit into Q and QM, selecting the source register per digit.
   // NOTE: registers are written with <= so every update in this edge reads
   // the pre-edge values of both q and qm; blocking writes would corrupt qm.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q  <= '0;
         qm <= '1;
      end else if (clr) begin
         q  <= '0;
         qm <= '1;
      end else if (en) begin
         case (digit)
            SD_POS: begin
               q  <= {q[NDIG-1:0], 1'b1};
               qm <= {q[NDIG-1:0], 1'b0};
            end
            SD_NEG: begin
               q  <= {qm[NDIG-1:0], 1'b1};
               qm <= {qm[NDIG-1:0], 1'b0};
            end
            default: begin
               q  <= {q[NDIG-1:0], 1'b0};
               qm <= {qm[NDIG-1:0], 1'b1};
            end
         endcase
      end
   end

endmodule : otf_converter

// File: rtl/online_quotient_collector.sv
// Online quotient collector: accepts NDIG signed digits over a valid/ready
// handshake, converts them on the fly, and presents the finished
// two's-complement quotient on a parallel valid/ready port.
module online_quotient_collector
   import online_quotient_collector_pkg::*;
#(
   parameter int NDIG = 8,
   parameter int CW   = 4   // must satisfy 2**CW > NDIG
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [1:0]      q_digit,
   input  logic            q_vd,
   output logic            q_rd,
   output logic [NDIG:0]   res_value,
   output logic            res_vd,
   input  logic            res_rd,
   output logic            res_err,
   output logic [CW-1:0]   digit_cnt
);

   state_t          state;
   logic [NDIG:0]   q;
   logic [NDIG:0]   qm;
   logic [NDIG:0]   q_final;
   logic            xfer;
   logic            accept;
   logic            last_digit;

   assign xfer       = (state == COLLECT) && q_vd && q_rd;
   assign accept     = (state == HOLD) && res_vd && res_rd;
   assign last_digit = (digit_cnt == CW'(NDIG - 1));

   otf_converter #(
      .NDIG (NDIG)
   ) u_conv (
      .clk   (clk),
      .rst   (rst),
      .clr   (accept),
      .en    (xfer),
      .digit (q_digit),
      .q     (q),
      .qm    (qm)
   );

   // Value Q takes once the current digit is applied; captured as the result on the last transfer.
   // NOTE: every output of a combinational block gets a default first so no
   // path through the case leaves it unassigned and infers a latch.
   always_comb begin
      q_final = {q[NDIG-1:0], 1'b0};
      case (q_digit)
         SD_POS:  q_final = {q[NDIG-1:0], 1'b1};
         SD_NEG:  q_final = {qm[NDIG-1:0], 1'b1};
         default: q_final = {q[NDIG-1:0], 1'b0};
      endcase
   end

   // Collect/hold FSM with registered handshake outputs, digit counter and sticky error.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= COLLECT;
         q_rd      <= 1'b0;
         res_vd    <= 1'b0;
         res_err   <= 1'b0;
         res_value <= '0;
         digit_cnt <= '0;
      end else begin
         case (state)
            COLLECT: begin
               q_rd <= 1'b1;
               if (xfer) begin
                  digit_cnt <= digit_cnt + CW'(1);
                  if (q_digit == SD_BAD) begin
                     res_err <= 1'b1;
                  end
                  if (last_digit) begin
                     // Drop ready on this edge so the NDIG+1-th digit is never taken.
                     state     <= HOLD;
                     q_rd      <= 1'b0;
                     res_vd    <= 1'b1;
                     res_value <= q_final;
                  end
               end
            end
            HOLD: begin
               q_rd <= 1'b0;
               if (accept) begin
                  // One bubble cycle: ready returns only after the result leaves.
                  state     <= COLLECT;
                  res_vd    <= 1'b0;
                  q_rd      <= 1'b1;
                  res_err   <= 1'b0;
                  digit_cnt <= '0;
               end
            end
            default: begin
               state <= COLLECT;
            end
         endcase
      end
   end

endmodule : online_quotient_collector

// File: tb/tb_online_quotient_collector.sv
// Self-checking bench for online_quotient_collector: directed and random
// digit streams compared against an arithmetic model of the quotient value.
module tb_online_quotient_collector;

   localparam int NDIG = 8;
   localparam int CW   = 4;
   localparam int W    = NDIG + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [1:0]    q_digit = 2'b00;
   logic          q_vd = 1'b0;
   logic          q_rd;
   logic [W-1:0]  res_value;
   logic          res_vd;
   logic          res_rd = 1'b0;
   logic          res_err;
   logic [CW-1:0] digit_cnt;

   int errors = 0;
   int checks = 0;

   logic [1:0] digs [NDIG];
   int         gaps [NDIG];

   online_quotient_collector #(
      .NDIG (NDIG),
      .CW   (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .q_digit   (q_digit),
      .q_vd      (q_vd),
      .q_rd      (q_rd),
      .res_value (res_value),
      .res_vd    (res_vd),
      .res_rd    (res_rd),
      .res_err   (res_err),
      .digit_cnt (digit_cnt)
   );

   always #5 clk = ~clk;

   function automatic int sd_val(input logic [1:0] d);
      case (d)
         2'b10:   return 1;
         2'b01:   return -1;
         default: return 0;
      endcase
   endfunction

   // Quotient scaled by 2^NDIG: sum of d_i * 2^(NDIG-1-i).
   function automatic int model_value();
      int v = 0;
      for (int i = 0; i < NDIG; i++) v += sd_val(digs[i]) * (1 << (NDIG - 1 - i));
      return v;
   endfunction

   function automatic logic model_err();
      logic e = 1'b0;
      for (int i = 0; i < NDIG; i++) if (digs[i] == 2'b11) e = 1'b1;
      return e;
   endfunction

   task automatic load_digs(input logic [2*NDIG-1:0] v);
      for (int i = 0; i < NDIG; i++) begin
         digs[i] = v[2*(NDIG-1-i) +: 2];
         gaps[i] = 0;
      end
   endtask

   task automatic random_digs(input int max_gap);
      for (int i = 0; i < NDIG; i++) begin
         digs[i] = 2'($urandom_range(0, 3));
         gaps[i] = (max_gap == 0) ? 0 : $urandom_range(0, max_gap);
      end
   endtask

   // Feed the first n digits of digs[], checking counter, Q/QM and handshake after each transfer.
   task automatic feed(input int n);
      int acc = 0;
      int t;
      for (int i = 0; i < n; i++) begin
         if (gaps[i] > 0) q_vd = 1'b0;
         for (int g = 0; g < gaps[i]; g++) begin
            @(posedge clk); #1;
            checks++;
            if (digit_cnt !== CW'(i)) begin
               errors++;
               $display("FAIL gap_cnt digit %0d: got %0d want %0d", i, digit_cnt, i);
            end
         end
         q_digit = digs[i];
         q_vd    = 1'b1;
         t = 0;
         while (q_rd !== 1'b1 && t < 50) begin
            @(posedge clk); #1;
            t++;
         end
         checks++;
         if (q_rd !== 1'b1) begin
            errors++;
            $display("FAIL ready_timeout digit %0d: q_rd=%b want 1", i, q_rd);
            q_vd = 1'b0;
            return;
         end
         @(posedge clk); #1;
         acc = acc * 2 + sd_val(digs[i]);
         checks++;
         if (digit_cnt !== CW'(i + 1)) begin
            errors++;
            $display("FAIL cnt digit %0d: got %0d want %0d", i, digit_cnt, i + 1);
         end
         checks++;
         if (dut.u_conv.q !== W'(acc) || dut.u_conv.qm !== W'(acc - 1)) begin
            errors++;
            $display("FAIL q_qm digit %0d: q=%h qm=%h want q=%h qm=%h", i,
                     dut.u_conv.q, dut.u_conv.qm, W'(acc), W'(acc - 1));
         end
         checks++;
         if (i == NDIG - 1) begin
            if (res_vd !== 1'b1 || q_rd !== 1'b0) begin
               errors++;
               $display("FAIL done_hs: res_vd=%b q_rd=%b want 1 0", res_vd, q_rd);
            end
         end else if (res_vd !== 1'b0) begin
            errors++;
            $display("FAIL early_vd digit %0d: res_vd=%b want 0", i, res_vd);
         end
         if (gaps[i] == 0 && i + 1 < n && gaps[i+1] == 0) q_vd = 1'b1;
         else q_vd = 1'b0;
      end
      q_vd = 1'b0;
   endtask

   // Check the held result, accept it, and check the return to COLLECT.
   task automatic accept_result(input logic [W-1:0] exp_v, input logic exp_err, input string tag);
      checks++;
      if (res_vd !== 1'b1 || res_value !== exp_v || res_err !== exp_err) begin
         errors++;
         $display("FAIL %s result: vd=%b value=%h err=%b want vd=1 value=%h err=%b",
                  tag, res_vd, res_value, res_err, exp_v, exp_err);
      end
      res_rd = 1'b1;
      @(posedge clk); #1;
      res_rd = 1'b0;
      checks++;
      if (res_vd !== 1'b0 || q_rd !== 1'b1 || digit_cnt !== '0 || res_err !== 1'b0) begin
         errors++;
         $display("FAIL %s accept: vd=%b q_rd=%b cnt=%0d err=%b want 0 1 0 0",
                  tag, res_vd, q_rd, digit_cnt, res_err);
      end
   endtask

   task automatic check_cleared(input string tag);
      checks++;
      if (q_rd !== 1'b0 || res_vd !== 1'b0 || res_err !== 1'b0 ||
          res_value !== '0 || digit_cnt !== '0) begin
         errors++;
         $display("FAIL %s: q_rd=%b vd=%b err=%b value=%h cnt=%0d want all 0",
                  tag, q_rd, res_vd, res_err, res_value, digit_cnt);
      end
   endtask

   task automatic release_reset(input string tag);
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if (q_rd !== 1'b0) begin
         errors++;
         $display("FAIL %s pre_edge q_rd: got %b want 0", tag, q_rd);
      end
      @(posedge clk); #1;
      checks++;
      if (q_rd !== 1'b1) begin
         errors++;
         $display("FAIL %s post_edge q_rd: got %b want 1", tag, q_rd);
      end
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      #2;
      check_cleared("reset_state");
      release_reset("reset_release");
   endtask

   task automatic test_directed();
      load_digs(16'h8000); feed(NDIG); accept_result(9'h080, 1'b0, "half");
      load_digs(16'h6000); feed(NDIG); accept_result(9'h1C0, 1'b0, "minus_quarter");
      load_digs(16'h9555); feed(NDIG); accept_result(9'h001, 1'b0, "lsb_by_borrow");
      load_digs(16'h0302); feed(NDIG); accept_result(9'h001, 1'b1, "bad_digit");
      load_digs(16'h0000); feed(NDIG); accept_result(9'h000, 1'b0, "zero_after_bad");
   endtask

   task automatic test_hold_backpressure();
      logic [W-1:0] exp_v;
      random_digs(0);
      exp_v = W'(model_value());
      feed(NDIG);
      for (int c = 0; c < 20; c++) begin
         q_digit = 2'($urandom_range(0, 3));
         q_vd    = 1'b1;
         @(posedge clk); #1;
         checks++;
         if (res_value !== exp_v || q_rd !== 1'b0 || res_vd !== 1'b1 || digit_cnt !== CW'(NDIG)) begin
            errors++;
            $display("FAIL hold cycle %0d: value=%h q_rd=%b vd=%b cnt=%0d want %h 0 1 %0d",
                     c, res_value, q_rd, res_vd, digit_cnt, exp_v, NDIG);
         end
      end
      q_vd = 1'b0;
      accept_result(exp_v, model_err(), "hold_release");
      random_digs(0);
      exp_v = W'(model_value());
      feed(NDIG);
      accept_result(exp_v, model_err(), "after_hold");
   endtask

   task automatic test_random_gaps();
      for (int r = 0; r < 8; r++) begin
         random_digs(5);
         if (r == 0) gaps[3] = 5;
         feed(NDIG);
         accept_result(W'(model_value()), model_err(), "random_gaps");
      end
   endtask

   task automatic test_reset_mid();
      random_digs(0);
      feed(5);
      #3 rst = 1'b1;
      #1;
      check_cleared("reset_mid_result");
      release_reset("reset_mid_release");
      random_digs(0);
      feed(NDIG);
      #3 rst = 1'b1;
      #1;
      check_cleared("reset_in_hold");
      release_reset("reset_hold_release");
      random_digs(2);
      feed(NDIG);
      accept_result(W'(model_value()), model_err(), "after_reset");
   endtask

   initial begin
      test_reset();
      test_directed();
      test_hold_backpressure();
      test_random_gaps();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_online_quotient_collector
